// File: rtl/memory_unit_queued.sv
// In-order multi-cycle data memory: requests queue in a small FIFO and are serviced
// one at a time with a fixed access latency; completions are one-cycle tagged pulses.
module memory_unit_queued #(
    parameter int DATA_W  = 3,
    parameter int ADDR_W  = 2,
    parameter int ROB_W   = 2,
    parameter int LATENCY = 4,
    parameter int QDEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_is_write,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_wdata,
    input  logic [ROB_W-1:0]               req_rob_idx,
    input  logic                           flush,
    output logic                           busy,
    output logic                           resp_valid,
    output logic                           resp_is_write,
    output logic [DATA_W-1:0]              resp_rdata,
    output logic [ROB_W-1:0]               resp_rob_idx,
    output logic [$clog2(QDEPTH+1)-1:0]    q_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(QDEPTH + 1);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [ROB_W-1:0]  rob_idx;
    } req_t;

    typedef enum logic {IDLE, ACCESS} state_t;

    req_t              fifo_q [QDEPTH];
    req_t              req_in;
    req_t              op_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_in    = '{is_write: req_is_write, addr: req_addr,
                         wdata: req_wdata, rob_idx: req_rob_idx};
    assign req_ready = (q_count != CW'(QDEPTH)) && !flush;
    assign push      = req_valid && req_ready;
    // Pops happen only from IDLE, so throughput is one op per LATENCY+1 cycles.
    assign pop       = (state == IDLE) && (q_count != '0) && !flush;
    assign busy      = (state != IDLE) || (q_count != '0);

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= req_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      q_count <= q_count + CW'(1);
            else if (pop && !push) q_count <= q_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            op_q          <= '0;
            resp_valid    <= 1'b0;
            resp_is_write <= 1'b0;
            resp_rdata    <= '0;
            resp_rob_idx  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
        end else begin
            resp_valid    <= 1'b0;
            resp_is_write <= 1'b0;
            resp_rdata    <= '0;
            resp_rob_idx  <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        op_q  <= fifo_q[rd_ptr];
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        resp_valid    <= 1'b1;
                        resp_is_write <= op_q.is_write;
                        resp_rob_idx  <= op_q.rob_idx;
                        if (op_q.is_write) mem[op_q.addr] <= op_q.wdata;
                        else               resp_rdata     <= mem[op_q.addr];
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_unit_queued.sv
// Bench for memory_unit_queued: a queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, random traffic, and a second configuration.
module tb_memory_unit_queued;
    localparam int DW = 3, AW = 2, RW = 2, LAT = 4, QD = 2;
    localparam int CW = $clog2(QD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0, req_is_write = 1'b0, flush = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [RW-1:0] req_rob_idx = '0;
    logic          req_ready, busy, resp_valid, resp_is_write;
    logic [DW-1:0] resp_rdata;
    logic [RW-1:0] resp_rob_idx;
    logic [CW-1:0] q_count;

    logic          b_req_valid = 1'b0, b_req_is_write = 1'b0, b_flush = 1'b0;
    logic [3:0]    b_req_addr = '0;
    logic [7:0]    b_req_wdata = '0;
    logic [1:0]    b_req_rob_idx = '0;
    logic          b_req_ready, b_busy, b_resp_valid, b_resp_is_write;
    logic [7:0]    b_resp_rdata;
    logic [1:0]    b_resp_rob_idx;
    logic [1:0]    b_q_count;

    memory_unit_queued #(.DATA_W(DW), .ADDR_W(AW), .ROB_W(RW), .LATENCY(LAT), .QDEPTH(QD)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_write(req_is_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rob_idx(req_rob_idx), .flush(flush), .busy(busy), .resp_valid(resp_valid),
        .resp_is_write(resp_is_write), .resp_rdata(resp_rdata), .resp_rob_idx(resp_rob_idx),
        .q_count(q_count));

    memory_unit_queued #(.DATA_W(8), .ADDR_W(4), .ROB_W(2), .LATENCY(1), .QDEPTH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_is_write(b_req_is_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_rob_idx(b_req_rob_idx), .flush(b_flush), .busy(b_busy), .resp_valid(b_resp_valid),
        .resp_is_write(b_resp_is_write), .resp_rdata(b_resp_rdata), .resp_rob_idx(b_resp_rob_idx),
        .q_count(b_q_count));

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0, cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---- behavioural model: pending queue, one in-flight op due at a known edge ----
    typedef struct { bit w; int a; int d; int rob; } mreq_t;
    mreq_t mq[$];
    mreq_t cur;
    bit    infl;
    int    op_at;
    int    mmem [4];
    int    e_rv, e_wr, e_rd, e_rob;

    task automatic mreset();
        mq.delete();
        infl = 0;
        op_at = 0;
        for (int i = 0; i < 4; i++) mmem[i] = i;
        e_rv = 0; e_wr = 0; e_rd = 0; e_rob = 0;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) cyc++;          // rst_n only ever falls while clk is low
            if (!rst_n) begin
                mreset();
            end else begin
                bit do_push;
                do_push = req_valid && (mq.size() != QD) && !flush;
                e_rv = 0; e_wr = 0; e_rd = 0; e_rob = 0;
                if (infl && cyc == op_at) begin
                    e_rv = 1; e_wr = cur.w; e_rob = cur.rob;
                    if (cur.w) mmem[cur.a] = cur.d;
                    else       e_rd = mmem[cur.a];
                    infl = 0;
                end else if (!infl && mq.size() != 0 && !flush) begin
                    cur = mq.pop_front();
                    infl = 1;
                    op_at = cyc + LAT;
                end
                if (flush) mq.delete();
                if (do_push) mq.push_back('{w: req_is_write, a: int'(req_addr),
                                            d: int'(req_wdata), rob: int'(req_rob_idx)});
            end
        end
    end

    // ---- per-cycle compare plus response log for the directed scenarios ----
    typedef struct { int cyc; int rob; int rd; int wr; int busy; } rsp_t;
    rsp_t rq[$];
    bit   saw_stall = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("resp_valid", int'(resp_valid), e_rv);
            check("resp_is_write", int'(resp_is_write), e_wr);
            check("resp_rdata", int'(resp_rdata), e_rd);
            check("resp_rob_idx", int'(resp_rob_idx), e_rob);
            check("busy", int'(busy), int'(infl || mq.size() != 0));
            check("q_count", int'(q_count), mq.size());
            check("req_ready", int'(req_ready), int'(mq.size() != QD && !flush));
            if (req_valid && !req_ready && q_count == CW'(QD)) saw_stall = 1;
            if (resp_valid) rq.push_back('{cyc: cyc, rob: int'(resp_rob_idx), rd: int'(resp_rdata),
                                           wr: int'(resp_is_write), busy: int'(busy)});
        end
    end

    // Holds req_valid until accepted; leaves req_valid high so the next send is back-to-back.
    task automatic send(input bit w, input int a, input int d, input int rob, output int acc);
        @(posedge clk); #2;
        req_valid = 1'b1; req_is_write = w; req_addr = AW'(a);
        req_wdata = DW'(d); req_rob_idx = RW'(rob);
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready) begin acc = cyc + 1; break; end
        end
        check("send_accepted", int'(acc >= 0), 1);
    endtask

    task automatic drop();
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_n(input int n, input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (rq.size() >= n) break;
        end
        check(name, int'(rq.size() >= n), 1);
    endtask

    task automatic b_op(input bit w, input int a, input int d, input int rob,
                        output int lat, output int rd, output int wr);
        int acc, got;
        @(posedge clk); #2;
        b_req_valid = 1'b1; b_req_is_write = w; b_req_addr = 4'(a);
        b_req_wdata = 8'(d); b_req_rob_idx = 2'(rob);
        @(negedge clk);
        check("b_req_ready", int'(b_req_ready), 1);
        acc = cyc + 1;
        @(posedge clk); #2;
        b_req_valid = 1'b0;
        got = -1; rd = -1; wr = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_resp_valid) begin got = cyc; rd = int'(b_resp_rdata); wr = int'(b_resp_is_write); break; end
        end
        lat = got - acc;
        check("b_rob", int'(b_resp_rob_idx), rob);
    endtask

    initial begin
        int a0, a1, lat, rd, wr;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_q_count", int'(q_count), 0);
        check("rst_b_req_ready", int'(b_req_ready), 1);
        @(posedge clk); #2 rst_n = 1'b1;

        // Load addr 2: registered at accept+5, visible the following cycle.
        rq.delete();
        send(0, 2, 0, 1, a0); drop();
        wait_n(1, "t1_resp");
        if (rq.size() >= 1) begin
            check("t1_latency", rq[0].cyc - a0, 5);
            check("t1_rdata", rq[0].rd, 2);
            check("t1_rob", rq[0].rob, 1);
        end
        @(negedge clk);
        check("t1_pulse_width", int'(resp_valid), 0);

        // Store 5 to addr 3 then load addr 3.
        rq.delete();
        send(1, 3, 5, 0, a0); send(0, 3, 0, 2, a1); drop();
        wait_n(2, "t2_resp");
        if (rq.size() >= 2) begin
            check("t2_st_wr", rq[0].wr, 1);
            check("t2_st_rdata", rq[0].rd, 0);
            check("t2_ld_rdata", rq[1].rd, 5);
            check("t2_ld_rob", rq[1].rob, 2);
            check("t2_spacing", rq[1].cyc - rq[0].cyc, 5);
        end

        // Four back-to-back loads overflow the 2-entry queue.
        rq.delete(); saw_stall = 0;
        for (int i = 0; i < 4; i++) send(0, i, 0, i, a0);
        drop();
        wait_n(4, "t3_resp");
        check("t3_stall_seen", int'(saw_stall), 1);
        if (rq.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("t3_order", rq[i].rob, i);
            check("t3_rdata0", rq[0].rd, 0);
            check("t3_rdata3", rq[3].rd, 5);
            for (int i = 1; i < 4; i++) check("t3_spacing", rq[i].cyc - rq[i-1].cyc, 5);
        end

        // Flush during the first load's access drops the queued second load.
        rq.delete();
        send(0, 1, 0, 1, a0); send(0, 2, 0, 2, a1); drop();
        flush = 1'b1;
        @(posedge clk); #2 flush = 1'b0;
        @(negedge clk);
        check("t4_q_count", int'(q_count), 0);
        wait_n(1, "t4_resp");
        if (rq.size() >= 1) begin
            check("t4_rob", rq[0].rob, 1);
            check("t4_rdata", rq[0].rd, 1);
            check("t4_busy_at_resp", rq[0].busy, 0);
        end
        repeat (15) @(negedge clk);
        check("t4_single_resp", rq.size(), 1);

        // Reset mid-access aborts a store of 7 to addr 1.
        rq.delete();
        send(1, 1, 7, 3, a0); drop();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_resp", rq.size(), 0);
        send(0, 1, 0, 0, a0); drop();
        wait_n(1, "t5_resp");
        if (rq.size() >= 1) check("t5_rdata", rq[0].rd, 1);

        // Random traffic, flushes and occasional resets against the model.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #2;
            req_valid    = ($urandom_range(0, 9) < 6);
            req_is_write = 1'($urandom_range(0, 1));
            req_addr     = AW'($urandom_range(0, 3));
            req_wdata    = DW'($urandom_range(0, 7));
            req_rob_idx  = RW'($urandom_range(0, 3));
            flush        = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #5 rst_n = 1'b0;
                @(posedge clk); #2 rst_n = 1'b1;
            end
        end
        drop();
        flush = 1'b0;
        repeat (20) @(negedge clk);

        // Second configuration: LATENCY=1, 8-bit data, 16 words.
        b_op(0, 9, 0, 1, lat, rd, wr);
        check("b_latency", lat, 2);
        check("b_rdata9", rd, 9);
        b_op(1, 15, 200, 2, lat, rd, wr);
        check("b_st_latency", lat, 2);
        check("b_st_wr", wr, 1);
        check("b_st_rdata", rd, 0);
        b_op(0, 15, 0, 3, lat, rd, wr);
        check("b_ld_rdata", rd, 200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
